// File: rtl/midi_pkg.sv
// ============================================================================
// Module      : midi_pkg
// Description : MIDI 1.0 constants and encoder state type shared by TX/RX paths
// Revision    : 1.0
// ============================================================================
`default_nettype none

package midi_pkg;

    localparam logic [3:0] NOTE_OFF  = 4'h8;
    localparam logic [3:0] NOTE_ON   = 4'h9;
    localparam logic [7:0] DATA_MASK = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_DATA1  = 2'd2,
        ST_DATA2  = 2'd3
    } encState_t;

    function automatic logic [7:0] statusByte(input logic [3:0] kind, input logic [3:0] chan);
        return {kind, chan};
    endfunction

    // Data bytes always have bit 7 clear so they can never be taken for a status.
    function automatic logic [7:0] dataByte(input logic [6:0] value);
        return {1'b0, value} & DATA_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/midi_running_status.sv
// ============================================================================
// Module      : midi_running_status
// Description : Last transmitted status byte with idle-time based expiry
// Revision    : 1.0
// ============================================================================
`default_nettype none

module midi_running_status #(
    parameter bit ENABLE     = 1'b1,
    parameter int RS_REFRESH = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_statusWr,
    input  logic [7:0] i_status,
    output logic [7:0] o_lastStatus,
    output logic       o_lastValid
);

    localparam int                c_cntW    = $clog2(RS_REFRESH + 1);
    localparam logic [c_cntW-1:0] c_refresh = c_cntW'(RS_REFRESH);

    logic [7:0]        r_lastStatus;
    logic              r_lastValid;
    logic [c_cntW-1:0] r_idleCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastStatus <= 8'h00;
            r_lastValid  <= 1'b0;
            r_idleCnt    <= '0;
        end else if (i_statusWr) begin
            r_lastStatus <= i_status;
            r_lastValid  <= ENABLE;
            r_idleCnt    <= '0;
        end else begin
            // Counter parks at the refresh value; validity drops once it gets there.
            if (r_idleCnt != c_refresh) begin
                r_idleCnt <= r_idleCnt + 1'b1;
            end else begin
                r_lastValid <= 1'b0;
            end
        end
    end

    assign o_lastStatus = r_lastStatus;
    assign o_lastValid  = r_lastValid;

endmodule

`default_nettype wire

// File: rtl/midi_note_encoder.sv
// ============================================================================
// Module      : midi_note_encoder
// Description : Note On/Off events to MIDI 1.0 byte stream for the UART TX FIFO
// Revision    : 1.0
// ============================================================================
`default_nettype none

module midi_note_encoder
    import midi_pkg::*;
#(
    parameter int    pMidiCh        = 0,
    parameter string pNoteOffMode   = "vel0",
    parameter int    pNoteOffVel    = 64,
    parameter string pRunningStatus = "yes",
    parameter int    pRsRefresh     = 1000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [6:0] iNoteNumber,
    input  logic [6:0] iVelocity,
    input  logic       iNoteOn,
    input  logic       iNoteOff,
    output logic       oReady,
    output logic [7:0] oMidiWd,
    output logic       oMidiWe,
    input  logic       iMidiFull,
    output logic       oBusy
);

    localparam logic [3:0] c_chan      = 4'(pMidiCh);
    localparam bit         c_mode8x    = (pNoteOffMode == "8x");
    localparam bit         c_rsEnable  = (pRunningStatus == "yes");
    localparam logic [7:0] c_onStatus  = statusByte(NOTE_ON, c_chan);
    localparam logic [7:0] c_offStatus = statusByte(c_mode8x ? NOTE_OFF : NOTE_ON, c_chan);
    localparam logic [6:0] c_offVel    = c_mode8x ? 7'(pNoteOffVel) : 7'd0;

    encState_t  r_state;
    encState_t  w_next;
    logic [6:0] r_note;
    logic [6:0] r_vel;
    logic [7:0] r_status;
    logic [7:0] r_wd;
    logic [7:0] w_wdNext;

    logic       w_req;
    logic       w_accept;
    logic       w_we;
    logic       w_skip;
    logic       w_statusWr;
    logic [7:0] w_newStatus;
    logic [6:0] w_newVel;
    logic [7:0] w_lastStatus;
    logic       w_lastValid;

    assign w_req       = iNoteOn | iNoteOff;
    // Simultaneous on/off requests resolve to Note Off.
    assign w_newStatus = iNoteOff ? c_offStatus : c_onStatus;
    assign w_newVel    = iNoteOff ? c_offVel :
                         (iVelocity == 7'd0) ? 7'd1 : iVelocity;
    assign w_skip      = c_rsEnable & w_lastValid & (w_lastStatus == w_newStatus);
    assign w_we        = (r_state != ST_IDLE) & ~iMidiFull;

    midi_running_status #(
        .ENABLE     (c_rsEnable),
        .RS_REFRESH (pRsRefresh)
    ) u_runningStatus (
        .clk          (iCLK),
        .rst          (iRST),
        .i_statusWr   (w_statusWr),
        .i_status     (r_status),
        .o_lastStatus (w_lastStatus),
        .o_lastValid  (w_lastValid)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wdNext   = r_wd;
        w_accept   = 1'b0;
        w_statusWr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (w_skip) begin
                        w_next   = ST_DATA1;
                        w_wdNext = dataByte(iNoteNumber);
                    end else begin
                        w_next   = ST_STATUS;
                        w_wdNext = w_newStatus;
                    end
                end
            end
            ST_STATUS: begin
                if (w_we) begin
                    w_statusWr = 1'b1;
                    w_next     = ST_DATA1;
                    w_wdNext   = dataByte(r_note);
                end
            end
            ST_DATA1: begin
                if (w_we) begin
                    w_next   = ST_DATA2;
                    w_wdNext = dataByte(r_vel);
                end
            end
            ST_DATA2: begin
                if (w_we) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output byte is loaded one state ahead so it is stable for the whole byte state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wd     <= 8'h00;
            r_note   <= 7'd0;
            r_vel    <= 7'd0;
            r_status <= 8'h00;
        end else begin
            r_wd <= w_wdNext;
            if (w_accept) begin
                r_note   <= iNoteNumber;
                r_vel    <= w_newVel;
                r_status <= w_newStatus;
            end
        end
    end

    assign oMidiWe = w_we;
    assign oMidiWd = r_wd;
    assign oReady  = (r_state == ST_IDLE);
    assign oBusy   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_midi_note_encoder.sv
// ============================================================================
// Module      : tb_midi_note_encoder
// Description : Directed vector bench for midi_note_encoder (vel0 and 8x builds)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_midi_note_encoder;

    typedef struct {
        bit         sel;       // 0: vel0 build, 1: 8x build
        bit         on;
        bit         off;
        logic [6:0] note;
        logic [6:0] vel;
        int         idle;
        int         fullFrom;
        int         fullLen;
        logic [7:0] stallWd;
        int         nBytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         readyAt;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [6:0] note = 7'd0;
    logic [6:0] vel  = 7'd0;
    logic       aOn  = 1'b0;
    logic       aOff = 1'b0;
    logic       bOn  = 1'b0;
    logic       bOff = 1'b0;
    logic       full = 1'b0;

    logic       aReady, aWe, aBusy, bReady, bWe, bBusy;
    logic [7:0] aWd, bWd;

    int nCmp = 0;
    int nBad = 0;

    vec_t vecs [12];

    always #5 clk = ~clk;

    midi_note_encoder #(
        .pMidiCh        (0),
        .pNoteOffMode   ("vel0"),
        .pNoteOffVel    (64),
        .pRunningStatus ("yes"),
        .pRsRefresh     (16)
    ) dutA (
        .iCLK        (clk),
        .iRST        (rst),
        .iNoteNumber (note),
        .iVelocity   (vel),
        .iNoteOn     (aOn),
        .iNoteOff    (aOff),
        .oReady      (aReady),
        .oMidiWd     (aWd),
        .oMidiWe     (aWe),
        .iMidiFull   (full),
        .oBusy       (aBusy)
    );

    midi_note_encoder #(
        .pMidiCh        (5),
        .pNoteOffMode   ("8x"),
        .pNoteOffVel    (64),
        .pRunningStatus ("yes"),
        .pRsRefresh     (1000000)
    ) dutB (
        .iCLK        (clk),
        .iRST        (rst),
        .iNoteNumber (note),
        .iVelocity   (vel),
        .iNoteOn     (bOn),
        .iNoteOff    (bOff),
        .oReady      (bReady),
        .oMidiWd     (bWd),
        .oMidiWe     (bWe),
        .iMidiFull   (full),
        .oBusy       (bBusy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input bit sel, output logic we, output logic [7:0] wd,
                          output logic rdy, output logic busy);
        we   = sel ? bWe    : aWe;
        wd   = sel ? bWd    : aWd;
        rdy  = sel ? bReady : aReady;
        busy = sel ? bBusy  : aBusy;
    endtask

    task automatic runVec(input string name, input vec_t v);
        logic [7:0] got [4];
        logic [7:0] exp [3];
        int         n;
        int         rk;
        bit         stallBad;
        bit         busyBad;
        logic       we, rdy, busy;
        logic [7:0] wd;
        n = 0; rk = 0; stallBad = 1'b0; busyBad = 1'b0;
        exp[0] = v.b0; exp[1] = v.b1; exp[2] = v.b2;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;

        repeat (v.idle) @(negedge clk);
        @(negedge clk);
        note = v.note;
        vel  = v.vel;
        full = 1'b0;
        if (v.sel) begin bOn = v.on; bOff = v.off; end
        else       begin aOn = v.on; aOff = v.off; end
        #1;
        sample(v.sel, we, wd, rdy, busy);
        chk({name, ":acceptReady"}, 32'(rdy), 32'd1);

        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            aOn = 1'b0; aOff = 1'b0; bOn = 1'b0; bOff = 1'b0;
            full = (k >= v.fullFrom) && (k < v.fullFrom + v.fullLen);
            #1;
            sample(v.sel, we, wd, rdy, busy);
            if (busy === rdy) busyBad = 1'b1;
            if (full && (we !== 1'b0 || wd !== v.stallWd)) stallBad = 1'b1;
            if (we === 1'b1) begin
                if (n < 4) got[n] = wd;
                n++;
            end
            if (rdy === 1'b1) begin
                rk = k;
                break;
            end
        end
        full = 1'b0;

        chk({name, ":byteCount"}, 32'(n), 32'(v.nBytes));
        for (int i = 0; i < 3; i++) begin
            if (i < v.nBytes && i < n) chk($sformatf("%s:byte%0d", name, i), 32'(got[i]), 32'(exp[i]));
        end
        chk({name, ":readyCycle"}, 32'(rk), 32'(v.readyAt));
        chk({name, ":busyInverse"}, 32'(busyBad), 32'd0);
        if (v.fullLen > 0) chk({name, ":stallHold"}, 32'(stallBad), 32'd0);
    endtask

    initial begin
        vec_t last;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset:aReady", 32'(aReady), 32'd1);
        chk("reset:aBusy",  32'(aBusy),  32'd0);
        chk("reset:aWe",    32'(aWe),    32'd0);
        chk("reset:aWd",    32'(aWd),    32'h00);
        chk("reset:bReady", 32'(bReady), 32'd1);
        chk("reset:bWd",    32'(bWd),    32'h00);
        rst = 1'b0;

        //           sel on off note    vel     idle ff fl stall  n  b0     b1     b2     rdy
        vecs[0]  = '{0, 1, 0, 7'd60, 7'd100, 0,  0, 0, 8'h00, 3, 8'h90, 8'h3C, 8'h64, 4};
        vecs[1]  = '{0, 1, 0, 7'd64, 7'd80,  0,  0, 0, 8'h00, 2, 8'h40, 8'h50, 8'h00, 3};
        vecs[2]  = '{0, 0, 1, 7'd60, 7'd99,  0,  0, 0, 8'h00, 2, 8'h3C, 8'h00, 8'h00, 3};
        vecs[3]  = '{0, 1, 0, 7'd60, 7'd100, 0,  1, 5, 8'h3C, 2, 8'h3C, 8'h64, 8'h00, 8};
        // Refresh window (16) has expired by now, so status goes out again.
        vecs[4]  = '{0, 1, 1, 7'd60, 7'd100, 0,  0, 0, 8'h00, 3, 8'h90, 8'h3C, 8'h00, 4};
        vecs[5]  = '{0, 1, 0, 7'd72, 7'd0,   0,  0, 0, 8'h00, 2, 8'h48, 8'h01, 8'h00, 3};
        vecs[6]  = '{0, 1, 0, 7'd60, 7'd100, 20, 0, 0, 8'h00, 3, 8'h90, 8'h3C, 8'h64, 4};
        vecs[7]  = '{0, 1, 0, 7'd62, 7'd100, 10, 0, 0, 8'h00, 2, 8'h3E, 8'h64, 8'h00, 3};
        vecs[8]  = '{1, 0, 1, 7'd60, 7'd100, 0,  0, 0, 8'h00, 3, 8'h85, 8'h3C, 8'h40, 4};
        vecs[9]  = '{1, 1, 0, 7'd60, 7'd100, 0,  0, 0, 8'h00, 3, 8'h95, 8'h3C, 8'h64, 4};
        vecs[10] = '{1, 1, 1, 7'd61, 7'd100, 0,  0, 0, 8'h00, 3, 8'h85, 8'h3D, 8'h40, 4};
        vecs[11] = '{1, 0, 1, 7'd62, 7'd10,  0,  0, 0, 8'h00, 2, 8'h3E, 8'h40, 8'h00, 3};

        for (int i = 0; i < 12; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset right after the status byte of a 8x-build message.
        @(negedge clk);
        note = 7'd60; vel = 7'd100; bOn = 1'b1;
        #1;
        chk("rstMid:acceptReady", 32'(bReady), 32'd1);
        @(negedge clk);
        bOn = 1'b0;
        #1;
        chk("rstMid:statusWe", 32'(bWe), 32'd1);
        chk("rstMid:statusWd", 32'(bWd), 32'h95);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) rst = 1'b0;
            #1;
            chk($sformatf("rstMid:noWrite%0d", k), 32'(bWe), 32'd0);
            chk($sformatf("rstMid:ready%0d", k), 32'(bReady), 32'd1);
        end
        chk("rstMid:wdCleared", 32'(bWd), 32'h00);

        last = '{1, 1, 0, 7'd60, 7'd100, 0, 0, 0, 8'h00, 3, 8'h95, 8'h3C, 8'h64, 4};
        runVec("afterReset", last);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

`default_nettype wire
